c5_imem_arbiter: RTL and testbench
==================================

C5_IMEM_ARBITER -- requirements
Module: c5_imem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, sets the data width of all data ports.
REQ-002 Parameter DEPTH, default 1024, sets memory size in 32-bit words; legal word index is 0..DEPTH-1.
REQ-003 I_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 I_rst_n  input  1  reset, synchronous and active-low.
REQ-005 I_f_stb  input  1  fetch-port request; level, held until O_f_ack.
REQ-006 I_f_adr  input  32  fetch byte address; read-only port.
REQ-007 O_f_dat  output  WIDTH  fetch read data; valid in the O_f_ack cycle.
REQ-008 O_f_ack  output  1  fetch completion; one-cycle pulse.
REQ-009 O_f_err  output  1  fetch out-of-range flag; valid with O_f_ack.
REQ-010 I_b_stb  input  1  bus-port (loader/debug) request; level, held until O_b_ack.
REQ-011 I_b_we  input  4  bus byte-write enables; 0 means read.
REQ-012 I_b_adr  input  32  bus byte address.
REQ-013 I_b_dat  input  WIDTH  bus write data.
REQ-014 O_b_dat  output  WIDTH  bus read data; valid in the O_b_ack cycle.
REQ-015 O_b_ack  output  1  bus completion; one-cycle pulse.
REQ-016 O_b_err  output  1  bus out-of-range flag; valid with O_b_ack.
REQ-017 O_m_stb, O_m_we[3:0], O_m_adr[31:0], O_m_dat[WIDTH-1:0]  outputs  drive the single-port instruction memory.
REQ-018 I_m_dat  input  WIDTH  memory read data; registered in the memory, valid one cycle after address presentation.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, ACK; every access follows IDLE->ISSUE->WAIT->ACK->IDLE, one state per cycle.
REQ-020 In IDLE with any request, the FSM SHALL latch the winner's adr/we/dat and move to ISSUE; with no request it SHALL stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: with both requests in the same IDLE cycle, the port that did not win last SHALL win; a single requester always wins.
REQ-022 The last-winner register SHALL update only on grant, and its reset value SHALL be "bus", so the fetch port wins the first contention.
REQ-023 In ISSUE, O_m_stb=1 with the latched O_m_adr/O_m_we/O_m_dat; O_m_we SHALL be 0 for fetch grants.
REQ-024 O_m_stb and O_m_we SHALL be 0 in every state except ISSUE.
REQ-025 O_m_adr SHALL hold its value through WAIT, and thereafter until the next grant.
REQ-026 At the end of WAIT, I_m_dat SHALL be captured into the granted port's data output; the other port's data output SHALL be unchanged.
REQ-027 In ACK, only the granted port's ack SHALL be 1, for exactly one cycle; request-to-ack latency is 3 cycles (request seen in cycle 0, ack in cycle 3).
REQ-028 Requests SHALL NOT be sampled in ISSUE, WAIT or ACK; a strobe still high in the first IDLE cycle after ACK SHALL be treated as a new request.
REQ-029 Out-of-range access: if latched adr[31:2] >= DEPTH, O_m_stb SHALL stay 0 in ISSUE, the port's data SHALL capture 0, and err=1 SHALL be given with ack; latency is unchanged.
REQ-030 For bus writes, O_b_dat SHALL return the pre-write word contents, as delivered by the memory.
REQ-031 Err outputs SHALL be 0 whenever the matching ack is 0.
REQ-032 Sustained requests on both ports SHALL alternate grants, with each access taking 4 cycles; neither port SHALL wait more than one foreign access.

Reset
REQ-033 When I_rst_n=0 at a clock edge: state SHALL become IDLE, last-winner SHALL become bus, and O_f_ack, O_b_ack, O_f_err, O_b_err, O_m_stb, O_m_we SHALL become 0.
REQ-034 The same reset SHALL clear O_f_dat, O_b_dat, O_m_adr and O_m_dat to 0.
REQ-035 Reset mid-access SHALL abandon that access with no ack issued; a write already strobed in ISSUE is not reverted.

Verification
REQ-036 Fetch-only read of 0x10: I_f_stb=1 in cycle 0 -> O_m_stb=1 and O_m_adr=0x10 in cycle 1; O_f_ack=1 and O_f_dat=mem[4] in cycle 3; O_f_err=0.
REQ-037 Bus write 0xDEADBEEF to 0x0 with we=4'b0011, then fetch 0x0 -> low half of the fetched word = 0xBEEF, upper bytes unchanged.
REQ-038 Both strobes high from the cycle after reset -> first ack on fetch (cycle 3), then bus (cycle 7), then fetch (cycle 11); grants strictly alternate.
REQ-039 Bus read of 4*DEPTH -> O_m_stb never asserted, O_b_ack=1 with O_b_err=1 and O_b_dat=0 in cycle 3.
REQ-040 I_rst_n=0 during WAIT -> no ack is issued; all outputs are 0 on the next cycle; the next contention is won by fetch.
REQ-041 Strobe held one cycle past ack -> exactly one extra access is performed, and its ack arrives 4 cycles after the first ack.

Source files
------------

// File: rtl/c5_imem_arbiter.sv
// c5_imem_arbiter
// Arbitrates a read-only instruction-fetch port and a loader/debug bus port
// onto one single-port instruction memory whose read data is registered
// (valid one cycle after the address is presented).
//
// Every access walks IDLE -> ISSUE -> WAIT -> ACK -> IDLE, one state per
// cycle, so a request seen in IDLE is acknowledged exactly three cycles later.
//
// Handshake: each port raises its stb as a level and holds it, with address
// and data stable, until it sees its ack. The ack is a single-cycle pulse;
// data and err are valid only in that cycle. The arbiter samples stb only in
// IDLE, so a stb still high in the IDLE cycle after ACK is a new request.
//
// Arbitration is round-robin between the two ports. The last-winner register
// resets to "bus" so the fetch port wins the first contention after reset.
//
// Out-of-range accesses (word index >= DEPTH) never strobe the memory; they
// complete with the same latency, return zero data and raise err with ack.
//
// O_state exposes the FSM state for observation.

module c5_imem_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  // fetch port (read-only)
  input  logic             I_f_stb,
  input  logic [31:0]      I_f_adr,
  output logic [WIDTH-1:0] O_f_dat,
  output logic             O_f_ack,
  output logic             O_f_err,
  // bus port (loader / debug)
  input  logic             I_b_stb,
  input  logic [3:0]       I_b_we,
  input  logic [31:0]      I_b_adr,
  input  logic [WIDTH-1:0] I_b_dat,
  output logic [WIDTH-1:0] O_b_dat,
  output logic             O_b_ack,
  output logic             O_b_err,
  // instruction memory side
  output logic             O_m_stb,
  output logic [3:0]       O_m_we,
  output logic [31:0]      O_m_adr,
  output logic [WIDTH-1:0] O_m_dat,
  input  logic [WIDTH-1:0] I_m_dat,
  // FSM state observation
  output logic [1:0]       O_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [1:0]  state;
  logic        last_bus;   // 1: bus port won the most recent grant
  logic        grant_bus;  // port owning the access in flight
  logic        oor_q;      // access in flight is out of range

  logic        any_req;
  logic        grant_bus_c;
  logic [31:0] sel_adr;
  logic [31:0] sel_word;
  logic        sel_oor;
  logic        start;

  assign O_state = state;

  // Grant decision for the current IDLE cycle: a lone requester wins,
  // contention goes to the port that did not win last time.
  always_comb begin
    any_req     = I_f_stb | I_b_stb;
    grant_bus_c = I_b_stb & (~I_f_stb | ~last_bus);
    sel_adr     = grant_bus_c ? I_b_adr : I_f_adr;
    sel_word    = {2'b00, sel_adr[31:2]};
    sel_oor     = (sel_word >= DEPTH_W);
    start       = (state == S_IDLE) & any_req;
  end

  // Access sequencer: latch the winner and walk through the fixed states.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state     <= S_IDLE;
      last_bus  <= 1'b1;
      grant_bus <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state     <= S_ISSUE;
            grant_bus <= grant_bus_c;
            last_bus  <= grant_bus_c;
            oor_q     <= sel_oor;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT:  state <= S_ACK;
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory request: strobe and write enables live only in ISSUE; address and
  // write data are loaded on grant and held until the next grant.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      O_m_stb <= 1'b0;
      O_m_we  <= 4'b0000;
      O_m_adr <= 32'h0;
      O_m_dat <= '0;
    end else if (start) begin
      O_m_stb <= ~sel_oor;
      O_m_we  <= (grant_bus_c & ~sel_oor) ? I_b_we : 4'b0000;
      O_m_adr <= sel_adr;
      O_m_dat <= grant_bus_c ? I_b_dat : '0;
    end else begin
      O_m_stb <= 1'b0;
      O_m_we  <= 4'b0000;
    end
  end

  // Response: at the end of WAIT the registered memory data (or zero for an
  // out-of-range access) lands on the granted port, which acks in ACK.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      O_f_dat <= '0;
      O_f_ack <= 1'b0;
      O_f_err <= 1'b0;
      O_b_dat <= '0;
      O_b_ack <= 1'b0;
      O_b_err <= 1'b0;
    end else begin
      O_f_ack <= 1'b0;
      O_f_err <= 1'b0;
      O_b_ack <= 1'b0;
      O_b_err <= 1'b0;
      if (state == S_WAIT) begin
        if (grant_bus) begin
          O_b_dat <= oor_q ? '0 : I_m_dat;
          O_b_ack <= 1'b1;
          O_b_err <= oor_q;
        end else begin
          O_f_dat <= oor_q ? '0 : I_m_dat;
          O_f_ack <= 1'b1;
          O_f_err <= oor_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_c5_imem_arbiter.sv
// Bench for c5_imem_arbiter: drives both ports with directed accesses against
// a small registered-read memory model; expected responses are queued per
// port when a request is issued and checked when the matching ack appears.

module tb_c5_imem_arbiter;

  localparam int W     = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int EW    = 65;  // {err, ack cycle[31:0], data[31:0]}

  logic          I_clk;
  logic          I_rst_n;
  logic          I_f_stb;
  logic [31:0]   I_f_adr;
  logic [W-1:0]  O_f_dat;
  logic          O_f_ack;
  logic          O_f_err;
  logic          I_b_stb;
  logic [3:0]    I_b_we;
  logic [31:0]   I_b_adr;
  logic [W-1:0]  I_b_dat;
  logic [W-1:0]  O_b_dat;
  logic          O_b_ack;
  logic          O_b_err;
  logic          O_m_stb;
  logic [3:0]    O_m_we;
  logic [31:0]   O_m_adr;
  logic [W-1:0]  O_m_dat;
  logic [W-1:0]  I_m_dat;
  logic [1:0]    O_state;

  c5_imem_arbiter #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n),
    .I_f_stb(I_f_stb), .I_f_adr(I_f_adr), .O_f_dat(O_f_dat),
    .O_f_ack(O_f_ack), .O_f_err(O_f_err),
    .I_b_stb(I_b_stb), .I_b_we(I_b_we), .I_b_adr(I_b_adr), .I_b_dat(I_b_dat),
    .O_b_dat(O_b_dat), .O_b_ack(O_b_ack), .O_b_err(O_b_err),
    .O_m_stb(O_m_stb), .O_m_we(O_m_we), .O_m_adr(O_m_adr), .O_m_dat(O_m_dat),
    .I_m_dat(I_m_dat), .O_state(O_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  // ---------------- memory model (registered read, byte writes) ----------------
  logic [31:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hC0DE_0000 | i;

  always @(posedge I_clk) begin
    if (O_m_stb) begin
      I_m_dat <= mem[O_m_adr[AW+1:2]];
      for (int k = 0; k < 4; k++)
        if (O_m_we[k]) mem[O_m_adr[AW+1:2]][8*k +: 8] <= O_m_dat[8*k +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] f_exp_q[$];
  logic [EW-1:0] b_exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the expected response whenever a port acks.
  always @(negedge I_clk) begin
    if (I_rst_n) begin
      if (O_f_ack) begin
        if (f_exp_q.size() == 0) flag("f_unexpected_ack");
        else begin
          mon_e = f_exp_q.pop_front();
          check("f_dat", O_f_dat, mon_e[31:0]);
          check("f_err", O_f_err, mon_e[64]);
          check("f_ack_cycle", cyc, mon_e[63:32]);
        end
      end else check("f_err_without_ack", O_f_err, 0);
      if (O_b_ack) begin
        if (b_exp_q.size() == 0) flag("b_unexpected_ack");
        else begin
          mon_e = b_exp_q.pop_front();
          check("b_dat", O_b_dat, mon_e[31:0]);
          check("b_err", O_b_err, mon_e[64]);
          check("b_ack_cycle", cyc, mon_e[63:32]);
        end
      end else check("b_err_without_ack", O_b_err, 0);
      check("dual_ack", O_f_ack & O_b_ack, 0);
      if (!O_m_stb) check("m_we_without_stb", O_m_we, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_f_ack();
    for (int i = 0; i < 20; i++) begin
      @(negedge I_clk);
      if (O_f_ack) return;
    end
    flag("f_ack_timeout");
  endtask

  task automatic wait_b_ack();
    for (int i = 0; i < 20; i++) begin
      @(negedge I_clk);
      if (O_b_ack) return;
    end
    flag("b_ack_timeout");
  endtask

  // Called just after a rising edge with the DUT in IDLE.
  task automatic do_fetch(input logic [31:0] adr, input logic [31:0] exp_dat, input logic exp_err);
    int t0;
    t0 = cyc;
    f_exp_q.push_back({exp_err, 32'(t0 + 3), exp_dat});
    I_f_adr = adr;
    I_f_stb = 1'b1;
    wait_f_ack();
    @(posedge I_clk); #1;
    I_f_stb = 1'b0;
  endtask

  task automatic do_bus(input logic [31:0] adr, input logic [3:0] we, input logic [31:0] dat,
                        input logic [31:0] exp_dat, input logic exp_err);
    int t0;
    t0 = cyc;
    b_exp_q.push_back({exp_err, 32'(t0 + 3), exp_dat});
    I_b_adr = adr;
    I_b_we  = we;
    I_b_dat = dat;
    I_b_stb = 1'b1;
    wait_b_ack();
    @(posedge I_clk); #1;
    I_b_stb = 1'b0;
    I_b_we  = 4'b0000;
  endtask

  task automatic apply_reset();
    I_rst_n = 1'b0;
    repeat (2) @(posedge I_clk);
    #1;
    I_rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_f_ack"}, O_f_ack, 0);
    check({tag, "_b_ack"}, O_b_ack, 0);
    check({tag, "_f_err"}, O_f_err, 0);
    check({tag, "_b_err"}, O_b_err, 0);
    check({tag, "_m_stb"}, O_m_stb, 0);
    check({tag, "_m_we"}, O_m_we, 0);
    check({tag, "_f_dat"}, O_f_dat, 0);
    check({tag, "_b_dat"}, O_b_dat, 0);
    check({tag, "_m_adr"}, O_m_adr, 0);
    check({tag, "_m_dat"}, O_m_dat, 0);
    check({tag, "_state"}, O_state, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    I_rst_n = 1'b0;
    I_f_stb = 1'b0; I_f_adr = 32'h0;
    I_b_stb = 1'b0; I_b_we = 4'b0; I_b_adr = 32'h0; I_b_dat = 32'h0;

    // reset state
    repeat (3) @(posedge I_clk);
    @(negedge I_clk);
    check_all_zero("reset");
    @(posedge I_clk); #1;
    I_rst_n = 1'b1;

    // fetch 0x10: memory strobed in cycle 1, data of word 4 acked in cycle 3
    fork
      do_fetch(32'h10, 32'hC0DE_0004, 1'b0);
      begin
        @(negedge I_clk); @(negedge I_clk);
        check("fetch_c1_m_stb", O_m_stb, 1);
        check("fetch_c1_m_adr", O_m_adr, 32'h10);
        check("fetch_c1_m_we", O_m_we, 0);
        @(negedge I_clk);
        check("fetch_c2_m_stb", O_m_stb, 0);
        check("fetch_c2_m_adr_hold", O_m_adr, 32'h10);
      end
    join

    // bus half-word write, returns the pre-write word
    fork
      do_bus(32'h0, 4'b0011, 32'hDEAD_BEEF, 32'hC0DE_0000, 1'b0);
      begin
        @(negedge I_clk); @(negedge I_clk);
        check("write_c1_m_stb", O_m_stb, 1);
        check("write_c1_m_we", O_m_we, 4'b0011);
        check("write_c1_m_dat", O_m_dat, 32'hDEAD_BEEF);
      end
    join
    do_fetch(32'h0, 32'hC0DE_BEEF, 1'b0);
    do_bus(32'h0, 4'b0000, 32'h0, 32'hC0DE_BEEF, 1'b0);

    // upper half-word write, then fetch it back
    do_bus(32'h8, 4'b1100, 32'h1234_5678, 32'hC0DE_0002, 1'b0);
    do_fetch(32'h8, 32'h1234_0002, 1'b0);

    // out of range: memory never strobed, zero data with err
    fork
      do_bus(32'(4 * DEPTH), 4'b0000, 32'h0, 32'h0, 1'b1);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge I_clk);
          check("oor_no_m_stb", O_m_stb, 0);
        end
      end
    join
    do_bus(32'(4 * DEPTH), 4'b1111, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_fetch(32'hFFFF_FFFC, 32'h0, 1'b1);
    do_fetch(32'(4 * DEPTH - 4), 32'hC0DE_003F, 1'b0);
    do_fetch(32'h0, 32'hC0DE_BEEF, 1'b0);  // rejected write left word 0 intact

    // sustained contention from the cycle after reset
    apply_reset();
    t0 = cyc;
    f_exp_q.push_back({1'b0, 32'(t0 + 3),  32'hC0DE_0001});
    b_exp_q.push_back({1'b0, 32'(t0 + 7),  32'hC0DE_0003});
    f_exp_q.push_back({1'b0, 32'(t0 + 11), 32'hC0DE_0001});
    b_exp_q.push_back({1'b0, 32'(t0 + 15), 32'hC0DE_0003});
    I_f_adr = 32'h4;  I_f_stb = 1'b1;
    I_b_adr = 32'hC;  I_b_we = 4'b0; I_b_stb = 1'b1;
    repeat (16) @(negedge I_clk);
    @(posedge I_clk); #1;
    I_f_stb = 1'b0; I_b_stb = 1'b0;
    repeat (4) @(posedge I_clk); #1;

    // reset during WAIT abandons the fetch and restores last-winner to bus
    do_bus(32'h20, 4'b0000, 32'h0, 32'hC0DE_0008, 1'b0);
    I_f_adr = 32'h4; I_f_stb = 1'b1;   // fetch wins, last winner = fetch
    repeat (3) @(negedge I_clk);       // cycle 2 (WAIT)
    check("mid_state_wait", O_state, 2);
    I_rst_n = 1'b0;
    @(negedge I_clk);
    check_all_zero("mid_reset");
    I_f_stb = 1'b0;
    @(posedge I_clk); #1;
    I_rst_n = 1'b1;
    t0 = cyc;
    f_exp_q.push_back({1'b0, 32'(t0 + 3), 32'hC0DE_0006});
    b_exp_q.push_back({1'b0, 32'(t0 + 7), 32'hC0DE_0007});
    I_f_adr = 32'h18; I_f_stb = 1'b1;
    I_b_adr = 32'h1C; I_b_we = 4'b0; I_b_stb = 1'b1;
    repeat (8) @(negedge I_clk);
    @(posedge I_clk); #1;
    I_f_stb = 1'b0; I_b_stb = 1'b0;
    repeat (2) @(posedge I_clk); #1;

    // stb held one cycle past ack: exactly one extra access, 4 cycles later
    t0 = cyc;
    f_exp_q.push_back({1'b0, 32'(t0 + 3), 32'hC0DE_0005});
    f_exp_q.push_back({1'b0, 32'(t0 + 7), 32'hC0DE_0005});
    I_f_adr = 32'h14; I_f_stb = 1'b1;
    repeat (4) @(negedge I_clk);
    @(posedge I_clk); #1;
    @(posedge I_clk); #1;
    I_f_stb = 1'b0;
    repeat (8) @(posedge I_clk); #1;

    check("f_queue_drained", f_exp_q.size(), 0);
    check("b_queue_drained", b_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
